// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor with valid/ready handshakes.
// Consumes DIGIT bits of each operand per clock, LSB first.
module serial_adder #(
  parameter int WIDTH = 6,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   S,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad
      $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [WIDTH-1:0]  sum;
  logic              carry;
  logic              a_msb;
  logic              b_msb;
  logic [CW-1:0]     cnt;

  logic [WIDTH-1:0]  b_eff;
  logic [DIGIT:0]    dsum;
  logic [WIDTH-1:0]  nxt_sum;
  logic              last;

  assign b_eff = sub ? ~B : B;

  always_comb begin
    dsum = {1'b0, a_sh[DIGIT-1:0]}
         + {1'b0, b_sh[DIGIT-1:0]}
         + {{DIGIT{1'b0}}, carry};
    last = (cnt == CW'(N - 1));
  end

  // New digit enters at the top; after N shifts the sum is aligned.
  generate
    if (DIGIT == WIDTH) begin : g_one
      assign nxt_sum = dsum[DIGIT-1:0];
    end else begin : g_many
      assign nxt_sum = {dsum[DIGIT-1:0], sum[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      sum   <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= A;
            b_sh  <= b_eff;
            sum   <= '0;
            carry <= sub;
            cnt   <= '0;
            a_msb <= A[WIDTH-1];
            b_msb <= b_eff[WIDTH-1];
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          sum   <= nxt_sum;
          carry <= dsum[DIGIT];
          cnt   <= cnt + 1'b1;
          if (last) begin
            cnt   <= '0;
            S     <= {dsum[DIGIT], nxt_sum};
            ovf   <= (a_msb == b_msb) &&
                     (nxt_sum[WIDTH-1] != a_msb);
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder, bit-serial and 3-bit-digit builds.
// Stimulus pushes expectations; per-instance monitors pop on out_valid.
module tb_serial_adder;

  typedef struct {
    logic [6:0] s;
    logic       ovf;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic       iv1, ir1, sub1, ov1, or1, of1;
  logic [5:0] a1, b1;
  logic [6:0] s1;
  logic       iv3, ir3, sub3, ov3, or3, of3;
  logic [5:0] a3, b3;
  logic [6:0] s3;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;
  logic seen1 = 1'b0;
  logic seen3 = 1'b0;

  serial_adder #(.WIDTH(6), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1),
    .A(a1), .B(b1), .sub(sub1),
    .out_valid(ov1), .out_ready(or1),
    .S(s1), .ovf(of1)
  );

  serial_adder #(.WIDTH(6), .DIGIT(3)) u3 (
    .clk(clk), .rst(rst),
    .in_valid(iv3), .in_ready(ir3),
    .A(a3), .B(b3), .sub(sub3),
    .out_valid(ov3), .out_ready(or3),
    .S(s3), .ovf(of3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Golden model: exact unsigned result plus signed-range overflow.
  function automatic exp_t model(input int a, input int b,
                                 input bit sb);
    exp_t e;
    int sa, sv, r;
    if (!sb) begin
      e.s = 7'(a + b);
    end else begin
      e.s[5:0] = 6'(a - b);
      e.s[6]   = (a >= b);
    end
    sa = (a >= 32) ? a - 64 : a;
    sv = (b >= 32) ? b - 64 : b;
    r  = sb ? sa - sv : sa + sv;
    e.ovf = (r > 31) || (r < -32);
    e.acc = 0;
    return e;
  endfunction

  task automatic issue1(input int a, input int b, input bit sb,
                        input logic [6:0] hs, input logic ho);
    int w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!ir1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ir1) begin
      timeout("accept1");
      return;
    end
    a1 = 6'(a); b1 = 6'(b); sub1 = sb; iv1 = 1'b1;
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    e = model(a, b, sb);
    chk("model_vs_hand_s", {25'd0, e.s}, {25'd0, hs});
    chk("model_vs_hand_ovf", {31'd0, e.ovf}, {31'd0, ho});
    e.s = hs;
    e.ovf = ho;
    e.acc = cyc;
    q1.push_back(e);
  endtask

  task automatic issue3(input int a, input int b, input bit sb);
    int w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!ir3 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ir3) begin
      timeout("accept3");
      return;
    end
    a3 = 6'(a); b3 = 6'(b); sub3 = sb; iv3 = 1'b1;
    @(posedge clk);
    #1;
    iv3 = 1'b0;
    e = model(a, b, sb);
    e.acc = cyc;
    q3.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      seen1 <= 1'b0;
    end else if (ov1 && !seen1) begin
      seen1 <= 1'b1;
      if (q1.size() == 0) begin
        timeout("unexpected_result1");
      end else begin
        e1 = q1.pop_front();
        chk("u1_S", {25'd0, s1}, {25'd0, e1.s});
        chk("u1_ovf", {31'd0, of1}, {31'd0, e1.ovf});
        chk("u1_latency", cyc - e1.acc, 6);
      end
    end else if (!ov1) begin
      seen1 <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      seen3 <= 1'b0;
    end else if (ov3 && !seen3) begin
      seen3 <= 1'b1;
      if (q3.size() == 0) begin
        timeout("unexpected_result3");
      end else begin
        e3 = q3.pop_front();
        chk("u3_S", {25'd0, s3}, {25'd0, e3.s});
        chk("u3_ovf", {31'd0, of3}, {31'd0, e3.ovf});
        chk("u3_latency", cyc - e3.acc, 2);
      end
    end else if (!ov3) begin
      seen3 <= 1'b0;
    end
  end

  task automatic drain;
    int w;
    w = 0;
    while ((q1.size() != 0 || q3.size() != 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (q1.size() != 0 || q3.size() != 0) timeout("drain");
    @(negedge clk);
  endtask

  initial begin
    int w;
    iv1 = 0; a1 = 0; b1 = 0; sub1 = 0; or1 = 1;
    iv3 = 0; a3 = 0; b3 = 0; sub3 = 0; or3 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, ir1}, 1);
    chk("rst_out_valid", {31'd0, ov1}, 0);
    chk("rst_S", {25'd0, s1}, 0);
    chk("rst_ovf", {31'd0, of1}, 0);
    chk("rst_in_ready3", {31'd0, ir3}, 1);

    issue1(63, 63, 1'b0, 7'h7E, 1'b0);
    issue1(31, 1, 1'b0, 7'h20, 1'b1);
    issue1(32, 32, 1'b0, 7'h40, 1'b1);
    issue1(5, 9, 1'b1, 7'h3C, 1'b0);
    issue1(9, 5, 1'b1, 7'h44, 1'b0);
    drain();

    or1 = 1'b0;
    issue1(10, 20, 1'b0, 7'h1E, 1'b0);
    w = 0;
    while (!ov1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ov1) timeout("bp_out_valid");
    for (int i = 0; i < 10; i++) begin
      iv1 = 1'b1;
      a1 = 6'($urandom);
      b1 = 6'($urandom);
      sub1 = 1'($urandom);
      @(negedge clk);
      chk("bp_out_valid", {31'd0, ov1}, 1);
      chk("bp_S", {25'd0, s1}, 32'h1E);
      chk("bp_ovf", {31'd0, of1}, 0);
      chk("bp_in_ready", {31'd0, ir1}, 0);
    end
    iv1 = 1'b0;
    or1 = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", {31'd0, ir1}, 1);

    issue1(7, 7, 1'b0, 7'h0E, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, ov1}, 0);
    chk("midrst_S", {25'd0, s1}, 0);
    chk("midrst_in_ready", {31'd0, ir1}, 1);
    q1.delete();
    #4;
    rst = 1'b0;
    issue1(1, 2, 1'b0, 7'h03, 1'b0);
    drain();

    issue3(45, 27, 1'b0);
    drain();
    for (int i = 0; i < 1000; i++) begin
      issue3(int'($urandom_range(0, 63)),
             int'($urandom_range(0, 63)),
             1'($urandom));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
